// File: rtl/vj_uart_fifo_bridge.sv
// vj_uart_fifo_bridge
// Responder for the application-side JTAG UART byte interface. The app
// writes bytes with an active-low strobe into the TX FIFO and reads bytes
// with an active-high strobe from the RX FIFO. The host side (virtual-JTAG
// shift logic) drains TX and fills RX through valid/ready byte streams.
//
// Handshake semantics (both host streams): a byte moves on a rising clock
// edge where valid and ready are both high; the source holds data stable
// while valid is high and ready is low. host_tx_valid_o and host_rx_ready_o
// come straight from registered flags, so neither depends on any input in
// the same cycle. One exception on RX: when the RX FIFO is full and the app
// pops in the same cycle, the incoming host byte is taken into the slot that
// pop frees, even though host_rx_ready_o reads low in that cycle.
//
// App strobes are edge-detected against a one-cycle history register. Only
// the falling edge of nwr_i writes and only the rising edge of rd_i reads,
// so holding a strobe produces a single transfer.
module vj_uart_fifo_bridge #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              nwr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              txmt,
    output logic              txfl,
    output logic              rxmt,
    output logic              rxfl,
    input  logic [DATA_W-1:0] host_rx_data_i,
    input  logic              host_rx_valid_i,
    output logic              host_rx_ready_o,
    output logic [DATA_W-1:0] host_tx_data_o,
    output logic              host_tx_valid_o,
    input  logic              host_tx_ready_i,
    output logic              ovf_o,
    input  logic              ovf_clr_i
);

    localparam int         DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    // Strobe edge-detect history
    logic              nwr_q, nwr_d;
    logic              rd_q, rd_d;

    // TX FIFO state (app -> host)
    logic [DATA_W-1:0] tx_mem_q [DEPTH];
    logic [AW-1:0]     tx_wr_ptr_q, tx_wr_ptr_d;
    logic [AW-1:0]     tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW:0]       tx_cnt_q, tx_cnt_d;
    logic              txmt_q, txmt_d;
    logic              txfl_q, txfl_d;

    // RX FIFO state (host -> app)
    logic [DATA_W-1:0] rx_mem_q [DEPTH];
    logic [AW-1:0]     rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0]     rx_rd_ptr_q, rx_rd_ptr_d;
    logic [AW:0]       rx_cnt_q, rx_cnt_d;
    logic              rxmt_q, rxmt_d;
    logic              rxfl_q, rxfl_d;

    // App-visible read data and sticky overflow
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;

    // Per-cycle events
    logic              wr_ev;
    logic              rd_ev;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_push;
    logic              rx_pop;
    logic              ovf_set;

    // Decode strobe edges and decide which FIFO operations happen this cycle.
    // Pops are gated by the registered empty flags; pushes into a full FIFO
    // are allowed only when the same FIFO pops in this cycle.
    always_comb begin
        wr_ev   = ~nwr_i & nwr_q;
        rd_ev   = rd_i & ~rd_q;
        tx_pop  = ~txmt_q & host_tx_ready_i;
        tx_push = wr_ev & (~txfl_q | tx_pop);
        rx_pop  = rd_ev & ~rxmt_q;
        rx_push = host_rx_valid_i & (~rxfl_q | rx_pop);
        ovf_set = (wr_ev & ~tx_push) | (rd_ev & rxmt_q);
    end

    // Next-state for the TX FIFO pointers, count and flags
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_push) begin
            tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (AW+1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (AW+1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
        txmt_d = (tx_cnt_d == '0);
        txfl_d = (tx_cnt_d == FULL_CNT);
    end

    // Next-state for the RX FIFO pointers, count and flags
    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        if (rx_push) begin
            rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (AW+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (AW+1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
        rxmt_d = (rx_cnt_d == '0);
        rxfl_d = (rx_cnt_d == FULL_CNT);
    end

    // Next-state for strobe history, app read data and the sticky overflow
    always_comb begin
        nwr_d  = nwr_i;
        rd_d   = rd_i;
        data_d = data_q;
        if (rx_pop) begin
            data_d = rx_mem_q[rx_rd_ptr_q];
        end
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO storage; contents are discarded by resetting pointers, not data
    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= data_i;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= host_rx_data_i;
        end
    end

    // Control and status registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            nwr_q       <= 1'b1;
            rd_q        <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            txmt_q      <= 1'b1;
            txfl_q      <= 1'b0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            rxmt_q      <= 1'b1;
            rxfl_q      <= 1'b0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            nwr_q       <= nwr_d;
            rd_q        <= rd_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            txmt_q      <= txmt_d;
            txfl_q      <= txfl_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            rxmt_q      <= rxmt_d;
            rxfl_q      <= rxfl_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign data_o          = data_q;
    assign txmt            = txmt_q;
    assign txfl            = txfl_q;
    assign rxmt            = rxmt_q;
    assign rxfl            = rxfl_q;
    assign ovf_o           = ovf_q;
    assign host_tx_valid_o = ~txmt_q;
    assign host_rx_ready_o = ~rxfl_q;
    assign host_tx_data_o  = tx_mem_q[tx_rd_ptr_q];

endmodule

// File: tb/tb_vj_uart_fifo_bridge.sv
// Bench for vj_uart_fifo_bridge: directed scenarios plus randomized traffic,
// all checked each cycle against a queue-based reference model of the two
// FIFOs, the strobe edge rules and the sticky overflow flag.
module tb_vj_uart_fifo_bridge;

    localparam int DEPTH = 16;

    // Clock and reset
    logic       clk;
    logic       nreset;

    // DUT inputs
    logic       nwr_i;
    logic [7:0] data_i;
    logic       rd_i;
    logic [7:0] host_rx_data_i;
    logic       host_rx_valid_i;
    logic       host_tx_ready_i;
    logic       ovf_clr_i;

    // DUT outputs
    logic [7:0] data_o;
    logic       txmt, txfl, rxmt, rxfl;
    logic       host_rx_ready_o;
    logic [7:0] host_tx_data_o;
    logic       host_tx_valid_o;
    logic       ovf_o;

    // Scoreboard / reference model state
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_data;
    logic       exp_ovf;
    logic       prev_nwr;
    logic       prev_rd;

    int errors;
    int checks;

    vj_uart_fifo_bridge #(.DATA_W(8), .AW(4)) dut (
        .clk_i           (clk),
        .nreset_i        (nreset),
        .nwr_i           (nwr_i),
        .data_i          (data_i),
        .rd_i            (rd_i),
        .data_o          (data_o),
        .txmt            (txmt),
        .txfl            (txfl),
        .rxmt            (rxmt),
        .rxfl            (rxfl),
        .host_rx_data_i  (host_rx_data_i),
        .host_rx_valid_i (host_rx_valid_i),
        .host_rx_ready_o (host_rx_ready_o),
        .host_tx_data_o  (host_tx_data_o),
        .host_tx_valid_o (host_tx_valid_o),
        .host_tx_ready_i (host_tx_ready_i),
        .ovf_o           (ovf_o),
        .ovf_clr_i       (ovf_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_tx_q.delete();
        exp_rx_q.delete();
        exp_data = 8'h00;
        exp_ovf  = 1'b0;
        prev_nwr = 1'b1;
        prev_rd  = 1'b0;
    endtask

    // Apply the behavioural rules to the inputs about to be clocked in
    task automatic model_edge();
        bit wr_ev, rd_ev, tx_pop, tx_push, rx_pop, rx_push, ovf_set;
        wr_ev   = !nwr_i && prev_nwr;
        rd_ev   = rd_i && !prev_rd;
        tx_pop  = (exp_tx_q.size() > 0) && host_tx_ready_i;
        tx_push = wr_ev && ((exp_tx_q.size() < DEPTH) || tx_pop);
        rx_pop  = rd_ev && (exp_rx_q.size() > 0);
        rx_push = host_rx_valid_i && ((exp_rx_q.size() < DEPTH) || rx_pop);
        ovf_set = (wr_ev && !tx_push) || (rd_ev && exp_rx_q.size() == 0);
        if (tx_pop) void'(exp_tx_q.pop_front());
        if (tx_push) exp_tx_q.push_back(data_i);
        if (rx_pop) exp_data = exp_rx_q.pop_front();
        if (rx_push) exp_rx_q.push_back(host_rx_data_i);
        if (ovf_set) exp_ovf = 1'b1;
        else if (ovf_clr_i) exp_ovf = 1'b0;
        prev_nwr = nwr_i;
        prev_rd  = rd_i;
    endtask

    task automatic check_all();
        check_eq("txmt", txmt, exp_tx_q.size() == 0);
        check_eq("txfl", txfl, exp_tx_q.size() == DEPTH);
        check_eq("rxmt", rxmt, exp_rx_q.size() == 0);
        check_eq("rxfl", rxfl, exp_rx_q.size() == DEPTH);
        check_eq("host_tx_valid", host_tx_valid_o, exp_tx_q.size() != 0);
        check_eq("host_rx_ready", host_rx_ready_o, exp_rx_q.size() != DEPTH);
        check_eq("data_o", data_o, exp_data);
        check_eq("ovf_o", ovf_o, exp_ovf);
        if (exp_tx_q.size() != 0) check_eq("host_tx_data", host_tx_data_o, exp_tx_q[0]);
    endtask

    // Driver: called at a falling edge, drives one cycle of inputs
    task automatic step(input logic nwr, input logic [7:0] din, input logic rd,
                        input logic hv, input logic [7:0] hd, input logic hr,
                        input logic clr);
        nwr_i           = nwr;
        data_i          = din;
        rd_i            = rd;
        host_rx_valid_i = hv;
        host_rx_data_i  = hd;
        host_tx_ready_i = hr;
        ovf_clr_i       = clr;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic app_write(input logic [7:0] b);
        step(1'b0, b, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
    endtask

    task automatic host_push(input logic [7:0] b);
        step(1'b1, 8'h00, 1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] first_rx;
        errors = 0;
        checks = 0;
        nreset = 1'b0;
        nwr_i = 1'b1; data_i = '0; rd_i = 1'b0;
        host_rx_valid_i = 1'b0; host_rx_data_i = '0;
        host_tx_ready_i = 1'b0; ovf_clr_i = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_all();
        @(negedge clk);
        nreset = 1'b1;
        idle();

        // Single write then host drains it
        step(1'b0, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("first_valid", host_tx_valid_o, 1);
        check_eq("first_data", host_tx_data_o, 8'h41);
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("first_drained", txmt, 1);

        // 26 writes into a 16-deep FIFO with host stalled
        for (int i = 0; i < 26; i++) app_write(8'(8'h41 + i));
        check_eq("tx_full", txfl, 1);
        check_eq("tx_ovf", ovf_o, 1);
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_order", host_tx_data_o, 8'(8'h41 + i));
            step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_eq("drain_empty", txmt, 1);
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("ovf_cleared", ovf_o, 0);

        // Write strobe held low for 5 cycles gives one entry
        for (int i = 0; i < 5; i++) step(1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
        check_eq("held_wr_data", host_tx_data_o, 8'h55);
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("held_wr_one", txmt, 1);

        // Host RX pushes, read strobe held 2 cycles gives one pop
        host_push(8'h31);
        host_push(8'h32);
        check_eq("rx_nonempty", rxmt, 0);
        step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("rd_first", data_o, 8'h31);
        step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("rd_held_one_pop", rxmt, 0);
        idle();
        step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("rd_second", data_o, 8'h32);
        check_eq("rd_empty", rxmt, 1);
        idle();

        // RX full with simultaneous host push and app read
        first_rx = 8'h80;
        for (int i = 0; i < 16; i++) host_push(8'(8'h80 + i));
        check_eq("rx_full", rxfl, 1);
        step(1'b1, 8'h00, 1'b1, 1'b1, 8'hC5, 1'b0, 1'b0);
        check_eq("rx_full_stays", rxfl, 1);
        check_eq("rx_full_oldest", data_o, first_rx);
        idle();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            idle();
        end
        check_eq("rx_full_last", data_o, 8'hC5);

        // Async reset mid-stream with 7 TX bytes queued and ovf set
        for (int i = 0; i < 7; i++) app_write(8'($urandom_range(0, 255)));
        step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
        #2 nreset = 1'b0;
        #1;
        check_eq("rst_txmt", txmt, 1);
        check_eq("rst_tx_valid", host_tx_valid_o, 0);
        check_eq("rst_ovf", ovf_o, 0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        idle();

        // Wrap tests on both FIFOs
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            host_push(8'($urandom_range(0, 255)));
            step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            idle();
        end

        // Randomized traffic in phases with different drain/fill biases
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                step(1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) < ((ph == 1) ? 3 : 1)),
                     8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 3) < ((ph == 2) ? 3 : ((ph == 0) ? 1 : 2))),
                     1'($urandom_range(0, 15) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
